// File: rtl/if_id_buffer_if.sv
// Fetch/Decode bus for the IF/ID pipeline register. The master side (Fetch and
// hazard logic) drives words and control; the slave side (the buffer) drives the Decode packet.
interface if_id_buffer_if;
  logic        stall;
  logic        flush;
  logic [15:0] instruction_in;
  logic [31:0] pc_in;
  logic [15:0] instruction_out;
  logic [15:0] immediate_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        imm_pending;

  modport master (
    output stall, flush, instruction_in, pc_in,
    input  instruction_out, immediate_out, pc_out, valid_out, imm_pending
  );

  modport slave (
    input  stall, flush, instruction_in, pc_in,
    output instruction_out, immediate_out, pc_out, valid_out, imm_pending
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline register that assembles opcode+immediate pairs into one Decode packet.
// Define IF_ID_PC_CAPTURE_EN to keep the PC registers; otherwise pc_out is tied to zero.
module if_id_buffer #(
  parameter logic [15:0] NOP_WORD     = 16'h0000,
  parameter int unsigned IMM_FLAG_BIT = 15
) (
  input  logic           clk,
  input  logic           reset,
  if_id_buffer_if.slave  bus
);

  typedef enum logic {
    FIRST    = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic [15:0] op_latch_q, op_latch_d;
  logic        imm_flag;

  assign imm_flag = bus.instruction_in[IMM_FLAG_BIT];

`ifdef IF_ID_PC_CAPTURE_EN
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_latch_q, pc_latch_d;
`endif

  // Priority: flush > stall > capture; reset is applied in the register process.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    imm_d      = imm_q;
    valid_d    = valid_q;
    pend_d     = pend_q;
    op_latch_d = op_latch_q;
`ifdef IF_ID_PC_CAPTURE_EN
    pc_d       = pc_q;
    pc_latch_d = pc_latch_q;
`endif

    if (bus.flush) begin
      state_d    = FIRST;
      instr_d    = NOP_WORD;
      imm_d      = '0;
      valid_d    = 1'b0;
      pend_d     = 1'b0;
      op_latch_d = '0;
`ifdef IF_ID_PC_CAPTURE_EN
      pc_d       = '0;
      pc_latch_d = '0;
`endif
    end else if (!bus.stall) begin
      unique case (state_q)
        FIRST: begin
          if (imm_flag) begin
            // Opcode of a two-word instruction: park it and present a bubble; pc_out holds.
            op_latch_d = bus.instruction_in;
`ifdef IF_ID_PC_CAPTURE_EN
            pc_latch_d = bus.pc_in;
`endif
            instr_d    = NOP_WORD;
            imm_d      = '0;
            valid_d    = 1'b0;
            pend_d     = 1'b1;
            state_d    = WAIT_IMM;
          end else begin
            instr_d    = bus.instruction_in;
            imm_d      = '0;
            valid_d    = 1'b1;
            pend_d     = 1'b0;
`ifdef IF_ID_PC_CAPTURE_EN
            pc_d       = bus.pc_in;
`endif
          end
        end
        WAIT_IMM: begin
          instr_d    = op_latch_q;
          imm_d      = bus.instruction_in;
          valid_d    = 1'b1;
          pend_d     = 1'b0;
`ifdef IF_ID_PC_CAPTURE_EN
          pc_d       = pc_latch_q;
`endif
          state_d    = FIRST;
        end
        default: state_d = FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FIRST;
      instr_q    <= NOP_WORD;
      imm_q      <= '0;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      op_latch_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      imm_q      <= imm_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
      op_latch_q <= op_latch_d;
    end
  end

`ifdef IF_ID_PC_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      pc_latch_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pc_latch_q <= pc_latch_d;
    end
  end

  assign bus.pc_out = pc_q;
`else
  logic unused_pc_in;
  assign unused_pc_in = ^bus.pc_in;
  assign bus.pc_out   = '0;
`endif

  assign bus.instruction_out = instr_q;
  assign bus.immediate_out   = imm_q;
  assign bus.valid_out       = valid_q;
  assign bus.imm_pending     = pend_q;

endmodule
